mac_timestep_sequencer: RTL

- Controller for the synaptic-weight accumulation path of one neuron.
- Holds the neuron's synapse table (source address, FP32 weight per synapse) and records incoming spikes per synapse during a timestep.
- At timestep end, snapshots the spikes and sequences each spiking synapse's weight through a shared external FP32 adder, one operation at a time.
- Presents the accumulated sum to the potential-update stage with a one-cycle valid strobe.

---
 rtl/snn_pkg.sv | 21 ++
 rtl/syn_prio_enc.sv | 23 ++
 rtl/mac_timestep_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared constants and FSM state encoding for the neuron synaptic
// accumulation path (table size, field widths, FP32 zero, sequencer states).
package snn_pkg;

    localparam int NUM_SYN = 5;
    localparam int ADDR_W  = 12;
    localparam int W_W     = 32;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    // Sequencer states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/syn_prio_enc.sv
// Lowest-index-first priority encoder over the synapse snapshot bitmap.
// Purely combinational so the selected synapse costs no cycle.
module syn_prio_enc #(
    parameter int N     = snn_pkg::NUM_SYN,
    parameter int IDX_W = snn_pkg::idx_width(N)
) (
    input  logic [N-1:0]     bitmap_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_set_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bitmap_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        any_set_o = |bitmap_i;
    end

endmodule

// File: rtl/mac_timestep_sequencer.sv
// Per-neuron synaptic weight accumulation controller. Records spikes per
// synapse during a timestep, then at timestep end feeds each spiking
// synapse's FP32 weight through a shared external adder one operation at a
// time and publishes the sum with a one-cycle valid strobe.
module mac_timestep_sequencer #(
    parameter int NUM_SYN     = snn_pkg::NUM_SYN,
    parameter int ADDR_W      = snn_pkg::ADDR_W,
    parameter int W_W         = snn_pkg::W_W,
    parameter int ADD_LATENCY = 1
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      cfg_load,
    input  logic [NUM_SYN*W_W-1:0]    weights_array,
    input  logic [NUM_SYN*ADDR_W-1:0] source_addresses_array,
    input  logic                      spike_valid,
    input  logic [ADDR_W-1:0]         source_address,
    input  logic                      timestep_end,
    output logic [W_W-1:0]            add_a,
    output logic [W_W-1:0]            add_b,
    input  logic [W_W-1:0]            add_result,
    output logic [W_W-1:0]            acc_out,
    output logic                      acc_valid,
    output logic                      busy,
    output logic                      unmatched_spike,
    output logic                      overrun
);

    import snn_pkg::*;

    localparam int IDX_W = idx_width(NUM_SYN);
    localparam int CNT_W = idx_width(ADD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_LATENCY - 1);
    localparam logic [W_W-1:0]   ACC_ZERO = W_W'(FP32_ZERO);

    // Synapse table
    logic [W_W-1:0]    weight_q [NUM_SYN];
    logic [W_W-1:0]    weight_d [NUM_SYN];
    logic [ADDR_W-1:0] addr_q   [NUM_SYN];
    logic [ADDR_W-1:0] addr_d   [NUM_SYN];

    // Spike bookkeeping and sequencer state
    logic [NUM_SYN-1:0] pending_q, pending_d;
    logic [NUM_SYN-1:0] snap_q,    snap_d;
    logic [W_W-1:0]     acc_q,     acc_d;
    logic [1:0]         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [W_W-1:0]     acc_out_q, acc_out_d;
    logic               acc_valid_q, acc_valid_d;
    logic               unm_q,     unm_d;
    logic               ovr_q,     ovr_d;

    logic [NUM_SYN-1:0] match;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_any;
    logic [NUM_SYN-1:0] sel_onehot;
    logic [NUM_SYN-1:0] snap_left;

    syn_prio_enc #(
        .N     (NUM_SYN),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .bitmap_i  (snap_q),
        .idx_o     (sel_idx),
        .any_set_o (sel_any)
    );

    assign sel_onehot = NUM_SYN'(1) << sel_idx;
    assign snap_left  = snap_q & ~sel_onehot;

    // Address compare: every table entry matching the incoming spike source.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            match[i] = spike_valid && (addr_q[i] == source_address);
        end
    end

    // Table reload, accepted only while the sequencer is idle.
    always_comb begin
        weight_d = weight_q;
        addr_d   = addr_q;
        if (state_q == IDLE && cfg_load) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                weight_d[i] = weights_array[(NUM_SYN-1-i)*W_W +: W_W];
                addr_d[i]   = source_addresses_array[(NUM_SYN-1-i)*ADDR_W +: ADDR_W];
            end
        end
    end

    // Sequencer next-state: snapshot at timestep end, one add per spiking synapse.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | match;
        snap_d      = snap_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = 1'b0;
        unm_d       = spike_valid && (match == '0);
        ovr_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (timestep_end) begin
                    // A spike in this same cycle starts the new timestep.
                    snap_d    = pending_q;
                    pending_d = match;
                    acc_d     = ACC_ZERO;
                    cnt_d     = '0;
                    if (pending_q != '0) begin
                        state_d = ACCUM;
                    end else begin
                        state_d     = DONE;
                        acc_out_d   = ACC_ZERO;
                        acc_valid_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                ovr_d = timestep_end;
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    acc_d  = add_result;
                    snap_d = snap_left;
                    if (snap_left == '0) begin
                        state_d     = DONE;
                        acc_out_d   = add_result;
                        acc_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                ovr_d   = timestep_end;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synapse table registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                weight_q[i] <= '0;
                addr_q[i]   <= '0;
            end
        end else begin
            weight_q <= weight_d;
            addr_q   <= addr_d;
        end
    end

    // Sequencer, bitmap, accumulator and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            snap_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            unm_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            snap_q      <= snap_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            unm_q       <= unm_d;
            ovr_q       <= ovr_d;
        end
    end

    assign add_a           = (state_q == ACCUM && sel_any) ? acc_q : '0;
    assign add_b           = (state_q == ACCUM && sel_any) ? weight_q[sel_idx] : '0;
    assign acc_out         = acc_out_q;
    assign acc_valid       = acc_valid_q;
    assign busy            = (state_q != IDLE);
    assign unmatched_spike = unm_q;
    assign overrun         = ovr_q;

endmodule
